// File: rtl/fft_sq_mag_accumulator_pkg.sv
// Shared definitions for the FFT squared-magnitude accumulator.
// Provides the controller state encoding and the fixed depth of the
// accumulate pipeline, which runs from beat acceptance to the RAM write.
package fft_sq_mag_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2
  } state_t;

  // Accepted beat to RAM write, in cycles.
  localparam int unsigned PIPE_DEPTH = 4;

endpackage

// File: rtl/fft_sq_mag_accumulator_sq_mag_pipe.sv
// sq_mag_pipe: three-stage |x|^2 = re^2 + im^2 datapath with a valid chain
// and an index passthrough. It is usable by any magnitude path.
//   clock, reset    : rising-edge clock, synchronous active-low reset
//   in_valid/index  : input beat qualifier and bin index
//   in_re/in_im     : signed input sample
//   s1_valid/index  : stage-1 view, used by callers to launch a read
//   s2_valid        : stage-2 occupancy
//   s3_valid/index  : result qualifier and bin index
//   s3_sum          : unsigned re^2 + im^2, 2*DATA_W+1 bits
module sq_mag_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_index,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     s1_valid,
  output logic [IDX_W-1:0]         s1_index,
  output logic                     s2_valid,
  output logic                     s3_valid,
  output logic [IDX_W-1:0]         s3_index,
  output logic [2*DATA_W:0]        s3_sum
);

  localparam int unsigned PW = 2 * DATA_W;

  logic signed [DATA_W-1:0] s1_re;
  logic signed [DATA_W-1:0] s1_im;
  logic signed [PW-1:0]     rr_c;
  logic signed [PW-1:0]     ii_c;
  logic [PW-1:0]            s2_rr;
  logic [PW-1:0]            s2_ii;
  logic [IDX_W-1:0]         s2_index;

  // Squares of signed values are non-negative, so the product bits are
  // reinterpreted as unsigned; (-2^(W-1))^2 still fits in 2*W bits.
  assign rr_c = PW'(s1_re) * PW'(s1_re);
  assign ii_c = PW'(s1_im) * PW'(s1_im);

  // Valid chain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Datapath registers; their contents are qualified by the valid chain.
  always_ff @(posedge clock) begin
    s1_re    <= in_re;
    s1_im    <= in_im;
    s1_index <= in_index;
    s2_rr    <= rr_c;
    s2_ii    <= ii_c;
    s2_index <= s1_index;
    s3_sum   <= {1'b0, s2_rr} + {1'b0, s2_ii};
    s3_index <= s2_index;
  end

endmodule

// File: rtl/fft_sq_mag_accumulator.sv
// fft_sq_mag_accumulator: computes the per-bin power spectrum of the FFT
// output stream, sums it over 2^AVG_LOG2 frames in an internal RAM, and then
// dumps the average (sum >> AVG_LOG2) for bins 0..N-1 over valid/ready.
// Optional macro FFT_SQ_MAG_SAT_EN selects saturating accumulation and adds
// the sticky sat_flag output. Without it, accumulation wraps modulo 2^ACC_W.
// Ports:
//   clock, reset            : clock, synchronous active-low reset
//   dv_in, xk_index         : one FFT bin per cycle, with its index
//   xk_re, xk_im            : signed bin value
//   busy                    : dump in progress; input beats are dropped
//   out_valid/out_ready     : output handshake
//   out_index, out_power    : bin number and averaged power
//   frame_done              : pulse after the handshake of the last bin
//   overrun                 : sticky, a beat arrived while busy
//   sat_flag (macro only)   : sticky, an accumulation saturated
module fft_sq_mag_accumulator
  import fft_sq_mag_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FFT_LOG2 = 10,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned ACC_W    = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dv_in,
  input  logic [FFT_LOG2-1:0]      xk_index,
  input  logic signed [DATA_W-1:0] xk_re,
  input  logic signed [DATA_W-1:0] xk_im,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FFT_LOG2-1:0]      out_index,
  output logic [ACC_W-1:0]         out_power,
  output logic                     frame_done,
  output logic                     overrun
`ifdef FFT_SQ_MAG_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int unsigned N     = 1 << FFT_LOG2;
  localparam int unsigned FRAMES = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = 2 * DATA_W + 1;
  localparam int unsigned FC_W  = AVG_LOG2 + 1;
  localparam int unsigned TAG_W = PIPE_DEPTH - 1;

  state_t               state;
  logic [FFT_LOG2-1:0]  beat_cnt;
  logic [FFT_LOG2-1:0]  dump_addr;
  logic [FC_W-1:0]      frame_cnt;
  logic                 accept_c;
  logic                 hs_c;

  logic                 s1_valid;
  logic [FFT_LOG2-1:0]  s1_index;
  logic                 s2_valid;
  logic                 s3_valid;
  logic [FFT_LOG2-1:0]  s3_index;
  logic [SUM_W-1:0]     s3_sum;
  logic [TAG_W-1:0]     first_sr;

  logic [ACC_W-1:0]     acc_ram [N];
  logic [ACC_W-1:0]     rd_q;
  logic [ACC_W-1:0]     old_q;
  logic [FFT_LOG2-1:0]  rd_addr_c;
  logic [ACC_W-1:0]     sum_ext_c;
  logic [ACC_W-1:0]     wr_data_c;
  logic                 wr_en_c;
`ifdef FFT_SQ_MAG_SAT_EN
  logic [ACC_W:0]       add_wide_c;
  logic                 sat_hit_c;
`endif

  assign accept_c  = dv_in && !busy;
  assign hs_c      = out_valid && out_ready;
  assign out_index = dump_addr;
  assign out_power = rd_q >> AVG_LOG2;

  sq_mag_pipe #(
    .DATA_W (DATA_W),
    .IDX_W  (FFT_LOG2)
  ) u_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (accept_c),
    .in_index (xk_index),
    .in_re    (xk_re),
    .in_im    (xk_im),
    .s1_valid (s1_valid),
    .s1_index (s1_index),
    .s2_valid (s2_valid),
    .s3_valid (s3_valid),
    .s3_index (s3_index),
    .s3_sum   (s3_sum)
  );

  // First-frame tag rides alongside the pipe: the last beats of frame 0
  // are written after frame_cnt has already advanced.
  always_ff @(posedge clock) begin
    if (!reset) begin
      first_sr <= '0;
    end else begin
      first_sr <= {first_sr[TAG_W-2:0], accept_c && (frame_cnt == '0)};
    end
  end

  // Single read port: pipeline reads while accumulating, prefetch in dump.
  // On a handshake the next bin is fetched so back-to-back transfers run at
  // one bin per cycle; while stalled the same address is re-read.
  always_comb begin
    rd_addr_c = s1_index;
    if (state == DUMP) begin
      rd_addr_c = hs_c ? dump_addr + FFT_LOG2'(1) : dump_addr;
    end else if (!s1_valid) begin
      rd_addr_c = dump_addr;
    end
  end

  // Accumulate write: overwrite in the first frame, add afterwards.
  always_comb begin
    sum_ext_c = ACC_W'(s3_sum);
    wr_en_c   = s3_valid;
`ifdef FFT_SQ_MAG_SAT_EN
    add_wide_c = {1'b0, old_q} + {1'b0, sum_ext_c};
    sat_hit_c  = 1'b0;
    if (first_sr[TAG_W-1]) begin
      wr_data_c = sum_ext_c;
    end else if (add_wide_c[ACC_W]) begin
      wr_data_c = '1;
      sat_hit_c = s3_valid;
    end else begin
      wr_data_c = add_wide_c[ACC_W-1:0];
    end
`else
    wr_data_c = first_sr[TAG_W-1] ? sum_ext_c : old_q + sum_ext_c;
`endif
  end

  // Accumulator RAM, write port.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      acc_ram[s3_index] <= wr_data_c;
    end
  end

  // Registered read port; also the source of out_power during the dump.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= acc_ram[rd_addr_c];
    end
  end

  // Old value aligned with stage 3.
  always_ff @(posedge clock) begin
    old_q <= rd_q;
  end

`ifdef FFT_SQ_MAG_SAT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (sat_hit_c) begin
      sat_flag <= 1'b1;
    end
  end
`endif

  // Controller: frame counting, drain wait, dump sequencing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ACCUM;
      frame_cnt  <= '0;
      beat_cnt   <= '0;
      dump_addr  <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (dv_in && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        ACCUM: begin
          if (accept_c) begin
            if (beat_cnt == FFT_LOG2'(N - 1)) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + FC_W'(1);
              if (frame_cnt == FC_W'(FRAMES - 1)) begin
                state <= DRAIN;
              end
            end else begin
              beat_cnt <= beat_cnt + FFT_LOG2'(1);
            end
          end
        end
        DRAIN: begin
          // All writes have landed once the whole valid chain is empty.
          if (!s1_valid && !s2_valid && !s3_valid) begin
            state <= DUMP;
            busy  <= 1'b1;
          end
        end
        DUMP: begin
          out_valid <= 1'b1;
          if (hs_c) begin
            if (dump_addr == FFT_LOG2'(N - 1)) begin
              state      <= ACCUM;
              busy       <= 1'b0;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              frame_cnt  <= '0;
              dump_addr  <= '0;
            end else begin
              dump_addr <= dump_addr + FFT_LOG2'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sq_mag_accumulator.sv
// Directed bench for fft_sq_mag_accumulator with N=16 and two-frame averaging.
module tb_fft_sq_mag_accumulator;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FFT_LOG2 = 4;
  localparam int unsigned AVG_LOG2 = 1;
  localparam int unsigned ACC_W    = 36;
  localparam int          NB       = 16;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic                     dv_in = 1'b0;
  logic [FFT_LOG2-1:0]      xk_index = '0;
  logic signed [DATA_W-1:0] xk_re = '0;
  logic signed [DATA_W-1:0] xk_im = '0;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [FFT_LOG2-1:0]      out_index;
  logic [ACC_W-1:0]         out_power;
  logic                     frame_done;
  logic                     overrun;
`ifdef FFT_SQ_MAG_SAT_EN
  logic                     sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_pow [NB];

  fft_sq_mag_accumulator #(
    .DATA_W   (DATA_W),
    .FFT_LOG2 (FFT_LOG2),
    .AVG_LOG2 (AVG_LOG2),
    .ACC_W    (ACC_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dv_in      (dv_in),
    .xk_index   (xk_index),
    .xk_re      (xk_re),
    .xk_im      (xk_im),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_power  (out_power),
    .frame_done (frame_done),
    .overrun    (overrun)
`ifdef FFT_SQ_MAG_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int val_re(input int mode, input int fr, input int k);
    case (mode)
      0: return 3;
      1: return (k == 5) ? -32768 : 0;
      2: return k;
      3: return (fr == 0) ? k : 0;
      4: return -k;
      default: return 0;
    endcase
  endfunction

  function automatic int val_im(input int mode, input int fr, input int k);
    case (mode)
      0: return 4;
      1: return (k == 5) ? -32768 : 0;
      2: return 0;
      3: return (fr == 0) ? 0 : 2 * k;
      4: return k - 8;
      default: return 0;
    endcase
  endfunction

  function automatic longint pw(input int mode, input int fr, input int k);
    longint re;
    longint im;
    re = longint'(val_re(mode, fr, k));
    im = longint'(val_im(mode, fr, k));
    return re * re + im * im;
  endfunction

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) begin
      if (k[b]) r = r | (1 << (3 - b));
    end
    return r;
  endfunction

  // Two frames of stimulus, then the average expected per bin.
  task automatic send_frames(input int mode, input bit bitrev);
    int k;
    for (int fr = 0; fr < 2; fr++) begin
      for (int j = 0; j < NB; j++) begin
        k = bitrev ? rev4(j) : j;
        @(negedge clock);
        dv_in    = 1'b1;
        xk_index = FFT_LOG2'(k);
        xk_re    = DATA_W'(val_re(mode, fr, k));
        xk_im    = DATA_W'(val_im(mode, fr, k));
      end
    end
    @(negedge clock);
    dv_in = 1'b0;
    for (int i = 0; i < NB; i++) begin
      exp_pow[i] = 64'((pw(mode, 0, i) + pw(mode, 1, i)) >> 1);
    end
    check("drain_busy", 64'(busy), 64'(0));
    check("drain_valid", 64'(out_valid), 64'(0));
  endtask

  // Collect up to 'stop' bins, optionally with random ready and one
  // dropped-beat injection while busy.
  task automatic dump_check(input int stop, input bit rnd, input bit inject);
    int got;
    int cyc;
    bit stalled;
    bit injected;
    bit r;
    logic [FFT_LOG2-1:0] s_idx;
    logic [ACC_W-1:0]    s_pow;
    got = 0; cyc = 0; stalled = 1'b0; injected = 1'b0;
    s_idx = '0; s_pow = '0;
    while (got < stop && cyc < 500) begin
      @(negedge clock);
      cyc++;
      dv_in = 1'b0;
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_index", 64'(out_index), 64'(s_idx));
        check("stall_power", 64'(out_power), 64'(s_pow));
      end
      if (inject && busy && !injected && got >= 1) begin
        dv_in    = 1'b1;
        xk_index = FFT_LOG2'(12);
        xk_re    = DATA_W'(1000);
        xk_im    = DATA_W'(7);
        injected = 1'b1;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        if (got == 0) check("dump_busy", 64'(busy), 64'(1));
        check("dump_index", 64'(out_index), 64'(got));
        check("dump_power", 64'(out_power), exp_pow[got]);
        got++;
      end
      stalled = out_valid && !r;
      s_idx   = out_index;
      s_pow   = out_power;
    end
    dv_in = 1'b0;
    if (got < stop) check("dump_timeout", 64'(got), 64'(stop));
  endtask

  task automatic end_of_dump;
    @(negedge clock);
    check("frame_done_pulse", 64'(frame_done), 64'(1));
    check("post_dump_valid", 64'(out_valid), 64'(0));
    check("post_dump_busy", 64'(busy), 64'(0));
    @(negedge clock);
    check("frame_done_low", 64'(frame_done), 64'(0));
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_index", 64'(out_index), 64'(0));
    check("rst_power", 64'(out_power), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    reset = 1'b1;
    out_ready = 1'b1;

    // re=3, im=4 everywhere: average 25 per bin.
    send_frames(0, 1'b0);
    dump_check(NB, 1'b0, 1'b0);
    end_of_dump();

    // Full-scale negative value at bin 5 only; also proves the overwrite.
    send_frames(1, 1'b0);
    dump_check(NB, 1'b0, 1'b0);
    end_of_dump();

    // Bit-reversed order, re=k: k^2 in natural order, random stalls,
    // and one beat offered while busy that must be dropped.
    check("pre_overrun", 64'(overrun), 64'(0));
    send_frames(2, 1'b1);
    dump_check(NB, 1'b1, 1'b1);
    end_of_dump();
    check("overrun_set", 64'(overrun), 64'(1));

    // Different frames summed (5k^2 >> 1 truncates); aborted by reset.
    send_frames(3, 1'b0);
    dump_check(6, 1'b1, 1'b0);
    check("overrun_sticky", 64'(overrun), 64'(1));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_overrun", 64'(overrun), 64'(0));
    reset = 1'b1;
    out_ready = 1'b1;

    // Fresh run after the abort with negative imaginary parts.
    send_frames(4, 1'b0);
    dump_check(NB, 1'b1, 1'b0);
    end_of_dump();
    check("final_overrun", 64'(overrun), 64'(0));
`ifdef FFT_SQ_MAG_SAT_EN
    check("sat_flag_clear", 64'(sat_flag), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
